// File: rtl/cdc_handshake_tx.sv
// Source-domain end of a two-phase req/ack CDC transfer: captures a word,
// toggles xfer_req, and waits for the resynchronised xfer_ack toggle.
module cdc_handshake_tx #(
  parameter int DATA_WIDTH     = 32,
  parameter int STAGES         = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  sync_clock,
  input  logic                  reset_n,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] xfer_data,
  output logic                  xfer_req,
  input  logic                  xfer_ack,
  output logic                  xfer_done,
  output logic                  busy,
  output logic                  timeout_err,
  input  logic                  clr_err
);

  // state    | meaning
  // IDLE     | ready to accept a word; ack_s should equal xfer_req
  // WAIT_ACK | word on xfer_data, req toggled, waiting for ack_s == xfer_req

  localparam bit TO_EN = (TIMEOUT_CYCLES > 0);
  localparam int CW    = TO_EN ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] T_MAX  = TO_EN ? CW'(TIMEOUT_CYCLES) : '0;
  localparam logic [CW-1:0] T_LAST = TO_EN ? CW'(TIMEOUT_CYCLES - 1) : '0;

  typedef enum logic {
    IDLE     = 1'b0,
    WAIT_ACK = 1'b1
  } state_t;

  state_t            state;
  logic [STAGES-1:0] ack_sync;
  logic              ack_s;
  logic [CW-1:0]     to_cnt;
  logic              ack_match;
  logic              to_hit;
  logic              spurious;
  logic              err_set;

  assign ack_s     = ack_sync[STAGES-1];
  assign ack_match = (ack_s == xfer_req);
  // Fires only on the edge the counter reaches the limit, so a clear while
  // saturated sticks.
  assign to_hit    = TO_EN && (state == WAIT_ACK) && !ack_match && (to_cnt == T_LAST);
  assign spurious  = TO_EN && (state == IDLE) && !ack_match;
  assign err_set   = to_hit || spurious;

  assign in_ready  = (state == IDLE);
  assign busy      = (state == WAIT_ACK);

  always_ff @(posedge sync_clock or negedge reset_n) begin
    if (!reset_n) begin
      ack_sync <= '0;
    end else begin
      ack_sync <= {ack_sync[STAGES-2:0], xfer_ack};
    end
  end

  always_ff @(posedge sync_clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      xfer_req    <= 1'b0;
      xfer_data   <= '0;
      to_cnt      <= '0;
      xfer_done   <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      xfer_done <= 1'b0;
      if (err_set) begin
        timeout_err <= 1'b1;
      end else if (clr_err) begin
        timeout_err <= 1'b0;
      end
      case (state)
        IDLE: begin
          if (in_valid) begin
            xfer_data <= in_data;
            xfer_req  <= ~xfer_req;
            to_cnt    <= '0;
            state     <= WAIT_ACK;
          end
        end
        WAIT_ACK: begin
          if (ack_match) begin
            state     <= IDLE;
            xfer_done <= 1'b1;
          end else if (TO_EN && (to_cnt != T_MAX)) begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cdc_handshake_tx.sv
// Directed plus randomized bench for cdc_handshake_tx; the destination side is
// modelled by driving xfer_ack to match the expected request level.
module tb_cdc_handshake_tx;

  localparam int DW = 32;
  localparam int ST = 2;
  localparam int TO = 8;

  logic          sync_clock;
  logic          reset_n;
  logic [DW-1:0] in_data;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] xfer_data;
  logic          xfer_req;
  logic          xfer_ack;
  logic          xfer_done;
  logic          busy;
  logic          timeout_err;
  logic          clr_err;

  int n_cmp = 0;
  int n_bad = 0;
  logic exp_req;
  logic exp_err;

  cdc_handshake_tx #(
    .DATA_WIDTH    (DW),
    .STAGES        (ST),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .sync_clock (sync_clock),
    .reset_n    (reset_n),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .xfer_data  (xfer_data),
    .xfer_req   (xfer_req),
    .xfer_ack   (xfer_ack),
    .xfer_done  (xfer_done),
    .busy       (busy),
    .timeout_err(timeout_err),
    .clr_err    (clr_err)
  );

  initial begin
    sync_clock = 1'b0;
    forever #5 sync_clock = ~sync_clock;
  end

  task automatic tick();
    @(posedge sync_clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    clr_err  = 1'b0;
    reset_n  = 1'b0;
    #1;
    chk("rst_req", xfer_req, 0);
    chk("rst_data", xfer_data, 0);
    chk("rst_ready", in_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", xfer_done, 0);
    chk("rst_err", timeout_err, 0);
    xfer_ack = 1'b0;
    exp_req  = 1'b0;
    exp_err  = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();
  endtask

  task automatic clr_pulse();
    in_valid = 1'b0;
    clr_err  = 1'b1;
    tick();
    clr_err = 1'b0;
    exp_err = 1'b0;
    chk("clr_err", timeout_err, 0);
  endtask

  // One complete transfer: ack returns d cycles after the accept; with keep the
  // source keeps in_valid high and moves on to nxt partway through the wait.
  task automatic run_xfer(input logic [DW-1:0] w, input int d, input bit keep,
                          input logic [DW-1:0] nxt);
    in_data  = w;
    in_valid = 1'b1;
    tick();
    exp_req = ~exp_req;
    chk("acc_req", xfer_req, exp_req);
    chk("acc_data", xfer_data, w);
    chk("acc_ready", in_ready, 0);
    chk("acc_busy", busy, 1);
    chk("acc_done", xfer_done, 0);
    if (keep) in_data = ~nxt;
    else in_valid = 1'b0;
    for (int i = 0; i < d; i++) begin
      if (keep && i == d / 2) in_data = nxt;
      tick();
      chk("wait_data", xfer_data, w);
      chk("wait_busy", busy, 1);
      chk("wait_done", xfer_done, 0);
    end
    if (keep) in_data = nxt;
    xfer_ack = exp_req;
    for (int i = 0; i < ST; i++) begin
      tick();
      chk("sync_data", xfer_data, w);
      chk("sync_busy", busy, 1);
      chk("sync_done", xfer_done, 0);
    end
    tick();
    chk("done_pulse", xfer_done, 1);
    chk("done_ready", in_ready, 1);
    chk("done_busy", busy, 0);
    chk("done_data", xfer_data, w);
    if (d + ST + 1 > TO) exp_err = 1'b1;
    chk("done_err", timeout_err, exp_err);
  endtask

  initial begin
    logic [DW-1:0] w;
    logic [DW-1:0] nxt;
    bit            keep;
    int            d;

    reset_n  = 1'b0;
    in_data  = '0;
    in_valid = 1'b0;
    xfer_ack = 1'b0;
    clr_err  = 1'b0;
    exp_req  = 1'b0;
    exp_err  = 1'b0;
    #12;
    do_reset();

    run_xfer(32'hDEADBEEF, 3, 1'b0, '0);

    do_reset();
    run_xfer(32'h1, 1, 1'b1, 32'h2);
    run_xfer(32'h2, 2, 1'b1, 32'h3);
    run_xfer(32'h3, 0, 1'b0, '0);

    run_xfer(32'h12345678, 4, 1'b1, 32'hA5);
    run_xfer(32'hA5, 1, 1'b0, '0);

    // Timeout with late ack, then clear.
    in_data  = 32'h00C0FFEE;
    in_valid = 1'b1;
    tick();
    exp_req  = ~exp_req;
    in_valid = 1'b0;
    for (int i = 1; i < TO; i++) begin
      tick();
      chk("to_pre_err", timeout_err, 0);
    end
    tick();
    chk("to_set_err", timeout_err, 1);
    chk("to_set_busy", busy, 1);
    repeat (3) begin
      tick();
      chk("to_sat_busy", busy, 1);
      chk("to_sat_err", timeout_err, 1);
    end
    xfer_ack = exp_req;
    repeat (ST) tick();
    tick();
    chk("late_done", xfer_done, 1);
    chk("late_err", timeout_err, 1);
    clr_pulse();

    // Set and clear on the same edge: set wins.
    in_data  = 32'h0BADF00D;
    in_valid = 1'b1;
    tick();
    exp_req  = ~exp_req;
    in_valid = 1'b0;
    for (int i = 1; i < TO; i++) tick();
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    chk("setwins_err", timeout_err, 1);
    xfer_ack = exp_req;
    repeat (ST) tick();
    tick();
    chk("setwins_done", xfer_done, 1);
    chk("setwins_data", xfer_data, 32'h0BADF00D);
    clr_pulse();

    w = $urandom;
    for (int n = 0; n < 12; n++) begin
      nxt  = $urandom;
      keep = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 1) == 1) d = $urandom_range(0, 4);
      else d = $urandom_range(6, 9);
      run_xfer(w, d, keep, nxt);
      if (exp_err) clr_pulse();
      w = keep ? nxt : $urandom;
    end

    // Spurious ack toggle while idle.
    in_valid = 1'b0;
    xfer_ack = ~exp_req;
    for (int i = 0; i < ST + 1; i++) begin
      tick();
      chk("spur_done", xfer_done, 0);
      chk("spur_ready", in_ready, 1);
      chk("spur_err", timeout_err, (i == ST) ? 1 : 0);
    end

    // Reset mid-transfer, then a clean transfer.
    do_reset();
    in_data  = 32'h77777777;
    in_valid = 1'b1;
    tick();
    chk("mid_busy", busy, 1);
    chk("mid_req", xfer_req, 1);
    in_valid = 1'b0;
    tick();
    do_reset();
    run_xfer(32'h5A5A5A5A, 2, 1'b0, '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/cdc_handshake_tx.md
Name: cdc_handshake_tx

Overview:
- Source-domain end of a two-phase (toggle) req/ack CDC data-transfer handshake.
- Accepts a word on a valid/ready interface in the sync_clock domain.
- Holds the word stable on a bus toward the destination domain, toggles a request level, then waits for the destination's acknowledge toggle.
- The acknowledge is resynchronised internally through a multi-flop chain. Pairs with the destination-side receiver, which synchronises xfer_req and returns xfer_ack.

Parameters:
- DATA_WIDTH, 32, width of the transferred word.
- STAGES, 2, flops in the xfer_ack synchroniser chain; legal range 2..4.
- TIMEOUT_CYCLES, 1024, sync_clock cycles in WAIT_ACK before timeout_err sets; 0 disables the timeout; counter width clog2(TIMEOUT_CYCLES+1).

Ports:
- sync_clock  in  1  source-domain clock.
- reset_n  in  1  asynchronous, active-low reset.
- in_data  in  DATA_WIDTH  word to transfer.
- in_valid  in  1  in_data valid.
- in_ready  out  1  block can accept a word.
- xfer_data  out  DATA_WIDTH  registered word to the destination; stable while a transfer is in flight.
- xfer_req  out  1  registered request level; toggles once per transfer.
- xfer_ack  in  1  asynchronous ack level from the destination; toggles once per completed transfer.
- xfer_done  out  1  one-cycle pulse when a transfer completes.
- busy  out  1  high in WAIT_ACK.
- timeout_err  out  1  sticky flag: an ack was not seen within TIMEOUT_CYCLES.
- clr_err  in  1  synchronous clear of timeout_err.

Behaviour:
- Reset (asynchronous, active-low reset_n, clock sync_clock):
  - State = IDLE; xfer_req = 0; xfer_data = 0; ack chain = 0; timeout counter = 0.
  - xfer_done = 0; timeout_err = 0; busy = 0; in_ready = 1.
- Ack synchroniser: STAGES-flop shift register clocked by sync_clock, input xfer_ack. ack_s is the last-stage output. No other logic reads xfer_ack directly.
- States:
  - IDLE: in_ready = 1, busy = 0.
  - WAIT_ACK: in_ready = 0, busy = 1.
  - in_ready and busy are decoded from the state register only, so they are glitch-free and independent of in_valid.
- IDLE -> WAIT_ACK on an edge where in_valid && in_ready:
  - xfer_data <= in_data.
  - xfer_req <= ~xfer_req.
  - Counter <= 0.
  - xfer_data and xfer_req update on the same edge, so data is stable before the destination can see the req toggle.
- WAIT_ACK -> IDLE on the first edge where ack_s == xfer_req:
  - xfer_done = 1 for exactly the following cycle.
  - xfer_data holds its value and is not cleared.
- Latency: xfer_ack toggles before edge M -> ack_s changes after edge M+STAGES-1 -> state is IDLE and xfer_done high after edge M+STAGES. Minimum accept-to-accept spacing is STAGES+2 cycles plus the destination round trip.
- in_valid while in WAIT_ACK is ignored; the word is not consumed and the source must hold it.
- Timeout:
  - In WAIT_ACK the counter increments each cycle and saturates at TIMEOUT_CYCLES.
  - When it reaches TIMEOUT_CYCLES, timeout_err <= 1.
  - The state stays WAIT_ACK; a late ack still completes the transfer normally.
  - timeout_err clears only on clr_err; if set and clear occur on the same edge, set wins.
  - TIMEOUT_CYCLES = 0: counter and flag are tied off and timeout_err stays 0.
- Spurious ack: an ack_s change while IDLE (ack_s != xfer_req) is a protocol violation. It sets timeout_err and otherwise has no effect. The next accept still toggles xfer_req, and that transfer completes when ack_s == xfer_req.
- Reset mid-transfer: returns to reset values immediately. The destination side must be reset in the same window; no recovery handshake is provided.
- All outputs are registered except in_ready and busy, which are pure decodes of the state register.

Test Plan:
- Single transfer, STAGES=2: reset, in_data=0xDEADBEEF with in_valid=1 for 1 cycle -> next cycle xfer_req=1, xfer_data=0xDEADBEEF, in_ready=0, busy=1. Model toggles xfer_ack 3 cycles later -> xfer_done pulses exactly 2 edges after the first ack-sampling edge; in_ready=1.
- Back-to-back: in_valid held high with 0x1, 0x2, 0x3 -> xfer_req sequence 1, 0, 1; each word is consumed only after the prior xfer_done; xfer_data never changes while busy=1.
- Back-pressure: assert in_valid with 0xA5 during WAIT_ACK and change in_data mid-wait -> xfer_data keeps the first word; 0xA5 is captured only after the return to IDLE.
- Timeout, TIMEOUT_CYCLES=8: no ack -> timeout_err=1 after 8 WAIT_ACK cycles with busy still 1. Late ack -> xfer_done fires and timeout_err stays 1. Then clr_err=1 -> timeout_err=0. Repeat with set and clr_err on the same edge -> timeout_err=1.
- Spurious ack in IDLE: toggle xfer_ack with no request -> timeout_err=1, no xfer_done, in_ready stays 1.
- Reset mid-transfer: assert reset_n=0 while busy=1 -> immediately xfer_req=0, xfer_data=0, in_ready=1, busy=0. Release with a fresh ack model -> a normal transfer of 0x5A5A5A5A completes.
